bus_transceiver: RTL and testbench

Parametrised multi-channel single-wire bus transceiver for sensor links such as the DHT11 data line.
- Each channel emulates an open-drain pin: it drives low or releases (Z), and never drives high; an external pull-up supplies the high level.
- Each channel generates host low pulses of programmable length, followed by a release guard window.
- Each channel returns a synchronised, glitch-filtered read level with edge strobes.
- Sits between the bus protocol FSMs and the top-level inout pins, replacing per-pin combinational tri-state buffers.

---
 rtl/bus_transceiver_pkg.sv | 19 +
 rtl/bus_input_filter.sv | 67 ++++++
 rtl/bus_transceiver.sv | 105 ++++++++++
 tb/tb_bus_transceiver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_transceiver_pkg.sv
// Shared types and constants for the single-wire bus transceiver.
package bus_transceiver_pkg;

  // Per-channel pulse sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GUARD = 2'd2
  } state_e;

  // Level of an idle, pulled-up bus.
  localparam logic READ_IDLE = 1'b1;

  // Width of a counter that must hold the values 0..filter_len.
  function automatic int unsigned filt_cnt_w(input int unsigned filter_len);
    return $clog2(filter_len + 1);
  endfunction

endpackage

// File: rtl/bus_input_filter.sv
// Two-flop synchroniser and run-length glitch filter for one bus pin.
module bus_input_filter
  import bus_transceiver_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pin_in,
  input  logic strobe_en,
  output logic read,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = filt_cnt_w(FILTER_LEN);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             read_q, read_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept a new level only after FILTER_LEN consecutive differing samples.
  always_comb begin
    sync1_d = pin_in;
    sync2_d = sync1_q;
    read_d  = read_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q != read_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        read_d = sync2_q;
        rise_d = strobe_en & sync2_q;
        fall_d = strobe_en & ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser and filter state; the bus is assumed high out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= READ_IDLE;
      sync2_q <= READ_IDLE;
      read_q  <= READ_IDLE;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      read_q  <= read_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign read = read_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/bus_transceiver.sv
// Multi-channel open-drain bus transceiver: timed low pulses plus filtered read-back.
module bus_transceiver
  import bus_transceiver_pkg::*;
#(
  parameter int unsigned CHANNELS     = 1,
  parameter int unsigned PULSE_W      = 20,
  parameter int unsigned FILTER_LEN   = 4,
  parameter int unsigned GUARD_CYCLES = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  inout  wire  [CHANNELS-1:0]           port,
  input  logic [CHANNELS-1:0]           start,
  input  logic [CHANNELS*PULSE_W-1:0]   low_cycles,
  output logic [CHANNELS-1:0]           busy,
  output logic [CHANNELS-1:0]           done,
  output logic [CHANNELS-1:0]           read,
  output logic [CHANNELS-1:0]           rise,
  output logic [CHANNELS-1:0]           fall
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_e               state_q, state_d;
    logic [PULSE_W-1:0]   cnt_q, cnt_d;
    logic                 drive_q, drive_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [PULSE_W-1:0]   len_c;
    logic                 idle_c;

    assign len_c  = low_cycles[c*PULSE_W +: PULSE_W];
    // Fully idle: sequencer at rest and the done cycle has passed.
    assign idle_c = (state_q == IDLE) && !busy_q;

    // Pulse sequencer; drive/busy/done are one register behind the state.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      drive_d = (state_q == DRIVE);
      busy_d  = (state_q != IDLE);
      done_d  = (state_q == IDLE) && busy_q;
      unique case (state_q)
        IDLE: begin
          if (idle_c && start[c] && (len_c != '0)) begin
            state_d = DRIVE;
            cnt_d   = len_c;
          end
        end
        DRIVE: begin
          cnt_d = cnt_q - PULSE_W'(1);
          if (cnt_q == PULSE_W'(1)) begin
            state_d = GUARD;
            cnt_d   = PULSE_W'(GUARD_CYCLES);
          end
        end
        GUARD: begin
          cnt_d = cnt_q - PULSE_W'(1);
          if (cnt_q == PULSE_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Sequencer registers; reset releases the pin at once.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        drive_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        drive_q <= drive_d;
        busy_q  <= busy_d;
        done_q  <= done_d;
      end
    end

    // Open drain: pull low or float, never drive high.
    assign port[c] = drive_q ? 1'b0 : 1'bz;
    assign busy[c] = busy_q;
    assign done[c] = done_q;

    bus_input_filter #(
      .FILTER_LEN(FILTER_LEN)
    ) u_filter (
      .clock    (clock),
      .reset_n  (reset_n),
      .pin_in   (port[c]),
      .strobe_en(idle_c),
      .read     (read[c]),
      .rise     (rise[c]),
      .fall     (fall[c])
    );
  end

endmodule

// File: tb/tb_bus_transceiver.sv
// Randomised and directed bench for bus_transceiver against a timeline model.
module tb_bus_transceiver;

  localparam int CH = 3;
  localparam int PW = 20;
  localparam int FL = 4;
  localparam int GC = 8;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  wire  [CH-1:0]        port;
  logic [CH-1:0]        start = '0;
  logic [CH-1:0]        pull = '0;
  logic [CH*PW-1:0]     low_cycles = '0;
  logic [CH-1:0]        busy, done, read, rise, fall;

  int checks = 0;
  int failures = 0;

  bus_transceiver #(
    .CHANNELS(CH), .PULSE_W(PW), .FILTER_LEN(FL), .GUARD_CYCLES(GC)
  ) dut (
    .clock(clock), .reset_n(reset_n), .port(port), .start(start),
    .low_cycles(low_cycles), .busy(busy), .done(done), .read(read),
    .rise(rise), .fall(fall)
  );

  // External open-drain device and pull-up on each line.
  for (genvar i = 0; i < CH; i++) begin : g_pin
    assign port[i] = pull[i] ? 1'b0 : 1'bz;
    pullup pu (port[i]);
  end

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Each accepted pulse at edge a with length L: pin low after edges a+1..a+L,
  // busy after a+1..a+L+GC, done after a+L+GC+1. Read flips when the last FL
  // pin levels seen two or more edges back all differ from it.
  int            cyc = 0;
  int            valid_from = 1;
  bit [CH-1:0]   active = '0;
  bit [CH-1:0]   m_drv = '0, m_busy = '0, m_done = '0;
  bit [CH-1:0]   m_read = '1, m_rise = '0, m_fall = '0;
  int            acc_a [CH];
  int            acc_low [CH];
  bit            hist [CH][32];

  function automatic bit h(input int c, input int j);
    if (j < valid_from) return 1'b1;
    return hist[c][j % 32];
  endfunction

  always @(posedge clock or negedge reset_n) begin : model
    int lo;
    bit flip;
    if (!reset_n) begin
      active = '0; m_drv = '0; m_busy = '0; m_done = '0;
      m_read = '1; m_rise = '0; m_fall = '0;
      valid_from = cyc + 1;
    end else begin
      cyc++;
      for (int c = 0; c < CH; c++) begin
        hist[c][cyc % 32] = !(m_drv[c] | pull[c]);
        if (active[c] && cyc > acc_a[c] + acc_low[c] + GC + 1) active[c] = 1'b0;
        lo = int'(low_cycles[c*PW +: PW]);
        if (!active[c] && start[c] && lo != 0) begin
          active[c] = 1'b1;
          acc_a[c] = cyc;
          acc_low[c] = lo;
        end
        m_drv[c]  = active[c] && cyc >= acc_a[c] + 1 && cyc <= acc_a[c] + acc_low[c];
        m_busy[c] = active[c] && cyc >= acc_a[c] + 1 && cyc <= acc_a[c] + acc_low[c] + GC;
        m_done[c] = active[c] && cyc == acc_a[c] + acc_low[c] + GC + 1;
        flip = 1'b1;
        for (int k = 2; k <= FL + 1; k++) if (h(c, cyc - k) == m_read[c]) flip = 1'b0;
        if (flip) m_read[c] = !m_read[c];
        m_rise[c] = flip && m_read[c] && !m_busy[c] && !m_done[c];
        m_fall[c] = flip && !m_read[c] && !m_busy[c] && !m_done[c];
      end
    end
  end

  // ---------------- checking ----------------
  int lowcnt [CH] = '{default: 0};
  int busycnt[CH] = '{default: 0};
  int donecnt[CH] = '{default: 0};
  int risecnt[CH] = '{default: 0};
  int fallcnt[CH] = '{default: 0};
  int last_low [CH] = '{default: 0};
  int last_done[CH] = '{default: 0};
  int prev_done[CH] = '{default: 0};
  int last_rise[CH] = '{default: 0};
  int last_fall[CH] = '{default: 0};
  int b_low[CH], b_busy[CH], b_done[CH], b_rise[CH], b_fall[CH];
  int pull_left[CH] = '{default: 0};

  function automatic int lvl(input logic v);
    return (v === 1'b1) ? 1 : ((v === 1'b0) ? 0 : 2);
  endfunction

  task automatic chk(input string nm, input int c, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s ch%0d actual=%0d expected=%0d edge=%0d", nm, c, act, exp, cyc);
    end
  endtask

  // Advance one cycle: compare on the falling edge, then step past it to drive.
  task automatic tick();
    @(negedge clock);
    if (reset_n) begin
      for (int c = 0; c < CH; c++) begin
        chk("port", c, lvl(port[c]), (m_drv[c] | pull[c]) ? 0 : 1);
        chk("busy", c, lvl(busy[c]), int'(m_busy[c]));
        chk("done", c, lvl(done[c]), int'(m_done[c]));
        chk("read", c, lvl(read[c]), int'(m_read[c]));
        chk("rise", c, lvl(rise[c]), int'(m_rise[c]));
        chk("fall", c, lvl(fall[c]), int'(m_fall[c]));
        if (lvl(port[c]) == 0) begin lowcnt[c]++; last_low[c] = cyc; end
        if (busy[c] === 1'b1) busycnt[c]++;
        if (done[c] === 1'b1) begin donecnt[c]++; prev_done[c] = last_done[c]; last_done[c] = cyc; end
        if (rise[c] === 1'b1) begin risecnt[c]++; last_rise[c] = cyc; end
        if (fall[c] === 1'b1) begin fallcnt[c]++; last_fall[c] = cyc; end
      end
    end
    #1;
  endtask

  task automatic snap();
    for (int c = 0; c < CH; c++) begin
      b_low[c] = lowcnt[c]; b_busy[c] = busycnt[c]; b_done[c] = donecnt[c];
      b_rise[c] = risecnt[c]; b_fall[c] = fallcnt[c];
    end
  endtask

  initial begin : stim
    int k, pc, rc;
    tick(); tick();
    for (int c = 0; c < CH; c++) chk("rst_port", c, lvl(port[c]), 1);
    chk("rst_busy", 0, int'(busy), 0);
    chk("rst_done", 0, int'(done), 0);
    chk("rst_read", 0, int'(read), 7);
    chk("rst_strobes", 0, int'(rise) + int'(fall), 0);
    reset_n = 1'b1;
    repeat (4) tick();

    // Single 18-cycle pulse.
    snap();
    low_cycles[0 +: PW] = 20'd18; start[0] = 1'b1; k = cyc + 1;
    tick(); start[0] = 1'b0;
    repeat (40) tick();
    chk("t1_low_cycles", 0, lowcnt[0] - b_low[0], 18);
    chk("t1_last_low", 0, last_low[0] - k, 18);
    chk("t1_busy_cycles", 0, busycnt[0] - b_busy[0], 26);
    chk("t1_done_count", 0, donecnt[0] - b_done[0], 1);
    chk("t1_done_edge", 0, last_done[0] - k, 27);
    chk("t1_strobes", 0, (risecnt[0] - b_rise[0]) + (fallcnt[0] - b_fall[0]), 0);

    // Zero-length request is ignored.
    snap();
    low_cycles[0 +: PW] = 20'd0; start[0] = 1'b1;
    repeat (5) tick(); start[0] = 1'b0;
    repeat (5) tick();
    chk("t2_busy", 0, busycnt[0] - b_busy[0], 0);
    chk("t2_low", 0, lowcnt[0] - b_low[0], 0);
    chk("t2_done", 0, donecnt[0] - b_done[0], 0);

    // Start held high: ignored while busy, re-accepted the cycle after done.
    snap();
    low_cycles[0 +: PW] = 20'd18; start[0] = 1'b1; k = cyc + 1;
    repeat (29) tick(); start[0] = 1'b0;
    repeat (60) tick();
    chk("t3_low_cycles", 0, lowcnt[0] - b_low[0], 36);
    chk("t3_busy_cycles", 0, busycnt[0] - b_busy[0], 52);
    chk("t3_done_count", 0, donecnt[0] - b_done[0], 2);
    chk("t3_first_done", 0, prev_done[0] - k, 27);
    chk("t3_second_done", 0, last_done[0] - k, 55);

    // External glitch shorter than the filter, then a real low pulse.
    snap();
    pull[0] = 1'b1; repeat (3) tick(); pull[0] = 1'b0;
    repeat (12) tick();
    chk("t4_glitch_fall", 0, fallcnt[0] - b_fall[0], 0);
    chk("t4_glitch_read", 0, lvl(read[0]), 1);
    snap();
    pull[0] = 1'b1; pc = cyc;
    repeat (6) tick(); pull[0] = 1'b0; rc = cyc;
    repeat (15) tick();
    chk("t4_fall_count", 0, fallcnt[0] - b_fall[0], 1);
    chk("t4_fall_delay", 0, last_fall[0] - pc, 6);
    chk("t4_rise_count", 0, risecnt[0] - b_rise[0], 1);
    chk("t4_rise_delay", 0, last_rise[0] - rc, 6);

    // Three channels started together with 5/10/15.
    snap();
    low_cycles = {20'd15, 20'd10, 20'd5}; start = '1; k = cyc + 1;
    tick(); start = '0;
    repeat (40) tick();
    chk("t5_done0_edge", 0, last_done[0] - k, 14);
    chk("t5_done_gap01", 1, last_done[1] - last_done[0], 5);
    chk("t5_done_gap12", 2, last_done[2] - last_done[1], 5);
    for (int c = 0; c < CH; c++) chk("t5_low_cycles", c, lowcnt[c] - b_low[c], 5 * (c + 1));

    // Reset four cycles into a 20-cycle pulse.
    snap();
    low_cycles[0 +: PW] = 20'd20; start[0] = 1'b1;
    tick(); start[0] = 1'b0;
    repeat (4) tick();
    chk("t6_low_before_reset", 0, lowcnt[0] - b_low[0], 4);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_port_z", 0, lvl(port[0]), 1);
    chk("t6_busy", 0, lvl(busy[0]), 0);
    chk("t6_read", 0, lvl(read[0]), 1);
    tick(); tick();
    reset_n = 1'b1;
    snap();
    repeat (40) tick();
    chk("t6_no_done", 0, donecnt[0] - b_done[0], 0);
    chk("t6_no_busy", 0, busycnt[0] - b_busy[0], 0);

    // Random traffic on all channels with external pulls.
    repeat (2500) begin
      for (int c = 0; c < CH; c++) begin
        start[c] = ($urandom_range(0, 7) == 0);
        low_cycles[c*PW +: PW] = PW'($urandom_range(0, 24));
        if (pull_left[c] > 0) begin
          pull_left[c]--;
          pull[c] = (pull_left[c] != 0);
        end else if ($urandom_range(0, 39) == 0) begin
          pull[c] = 1'b1;
          pull_left[c] = $urandom_range(1, 9);
        end
      end
      tick();
    end
    start = '0; pull = '0;
    repeat (40) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
